fp_mul_arbiter: RTL and testbench

Shares one pipelined single-precision multiplier (FPMul, fixed latency, fully pipelined, no stall) between NUM_REQ requesters. Each cycle one valid request is granted, its operands are driven to the multiplier, and a requester tag travels through a shadow pipeline of equal length so each product returns to its owner. Sits between the SIMT lanes' FP issue logic and the shared FPMul instance.

---
 rtl/fp_mul_arb_pkg.sv | 41 ++++
 rtl/fp_mul_arbiter_if.sv | 34 +++
 rtl/fp_mul_tag_pipe.sv | 44 ++++
 rtl/fp_mul_arbiter.sv | 113 +++++++++++
 tb/tb_fp_mul_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_arb_pkg
// Shared types and helpers for the FP multiplier arbiter.
//   FP_WIDTH  : operand / product width (single precision)
//   MAX_REQ   : largest supported requester count
//   ID_MAX_W  : requester-id width able to cover MAX_REQ
//   tag_t     : {valid, id} token that shadows one product through FPMul
//   onehot    : id -> one-hot vector
//   prio_enc  : lowest set bit -> index
// -----------------------------------------------------------------------------
package fp_mul_arb_pkg;

  localparam int FP_WIDTH = 32;
  localparam int MAX_REQ  = 16;
  localparam int ID_MAX_W = 4;

  typedef logic [ID_MAX_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic logic [MAX_REQ-1:0] onehot(input req_id_t id);
    logic [MAX_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

  // Lowest index wins; returns 0 for an empty vector.
  function automatic req_id_t prio_enc(input logic [MAX_REQ-1:0] vec);
    req_id_t idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = req_id_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter_if
// Bundles the requester handshake, the FPMul operand/result path and the
// response broadcast of fp_mul_arbiter.
//   slave  : the arbiter's view (drives req_ready, mul_a/b, resp_*, busy)
//   master : the environment's view (requesters plus the FPMul result)
// -----------------------------------------------------------------------------
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import fp_mul_arb_pkg::*;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*FP_WIDTH-1:0] req_a;
  logic [NUM_REQ*FP_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]          req_ready;
  logic [FP_WIDTH-1:0]         mul_a;
  logic [FP_WIDTH-1:0]         mul_b;
  logic [FP_WIDTH-1:0]         mul_q;
  logic [NUM_REQ-1:0]          resp_valid;
  logic [FP_WIDTH-1:0]         resp_data;
  logic                        busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_q,
    output req_ready, mul_a, mul_b, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_q,
    input  req_ready, mul_a, mul_b, resp_valid, resp_data, busy
  );

endinterface

// File: rtl/fp_mul_tag_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_tag_pipe
// LATENCY-deep shadow of the FPMul pipeline. The newest tag enters the top
// stage every edge and reaches stage 0 exactly when its product leaves FPMul.
//   clk, areset_n : clock, asynchronous active-low clear
//   tag_i         : {accept, granted id} for this cycle
//   tag_o         : tag aligned with the current FPMul output
//   busy_o        : any valid tag in flight
// -----------------------------------------------------------------------------
module fp_mul_tag_pipe
  import fp_mul_arb_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic areset_n,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  tag_t stage_q [LATENCY];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: the whole tag array is cleared, not just a pointer: a stale valid
      // bit would emit a phantom response for a product discarded at reset.
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
    end else begin
      // NOTE: non-blocking so every stage takes its neighbour's pre-edge value;
      // blocking here would collapse the shift into a single stage.
      stage_q[LATENCY-1] <= tag_i;
      for (int s = 0; s < LATENCY - 1; s++) stage_q[s] <= stage_q[s+1];
    end
  end

  assign tag_o = stage_q[0];

  always_comb begin
    busy_o = 1'b0;
    for (int s = 0; s < LATENCY; s++) busy_o = busy_o | stage_q[s].valid;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
// Shares one fixed-latency, fully pipelined FPMul among NUM_REQ requesters.
// One request is granted per cycle, its operands go to FPMul, and a tag of
// equal latency routes the product back to its owner.
//   clk, areset_n : clock, asynchronous active-low reset
//   bus (slave)   : req_valid/req_a/req_b/req_ready handshake, mul_a/mul_b to
//                   FPMul, mul_q from FPMul, resp_valid/resp_data, busy
// Configuration macro:
//   FP_MUL_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins), no rr_ptr.
//                              Undefined: round-robin starting at rr_ptr.
// -----------------------------------------------------------------------------
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             areset_n,
  fp_mul_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  tag_t            tag_in;
  tag_t            tag_out;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN

  always_comb begin
    grant_found = (|bus.req_valid) && areset_n;
    grant_id    = ID_W'(prio_enc(MAX_REQ'(bus.req_valid)));
  end

`else

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;

  // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ. One spare bit holds the
  // unwrapped sum so non-power-of-two counts wrap correctly.
  always_comb begin
    logic [ID_W:0] idx;
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    idx         = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant_found && bus.req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
    // Grants are suppressed while reset is held.
    if (!areset_n) grant_found = 1'b0;
  end

  assign rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)        rr_ptr_q <= '0;
    else if (grant_found) rr_ptr_q <= rr_ptr_d;
  end

`endif

  // Grant decode and operand mux; operands are zero when nothing is granted.
  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && (grant_id == ID_W'(i))) begin
        bus.req_ready[i] = 1'b1;
        bus.mul_a        = bus.req_a[FP_WIDTH*i +: FP_WIDTH];
        bus.mul_b        = bus.req_b[FP_WIDTH*i +: FP_WIDTH];
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_found;
    tag_in.id    = req_id_t'(grant_id);
  end

  fp_mul_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .areset_n (areset_n),
    .tag_i    (tag_in),
    .tag_o    (tag_out),
    .busy_o   (bus.busy)
  );

  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid[i] = tag_out.valid && (tag_out.id == req_id_t'(i));
    end
  end

  // Product is broadcast; only the owner's resp_valid qualifies it.
  assign bus.resp_data = bus.mul_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arbiter
// Directed bench for fp_mul_arbiter (NUM_REQ=4, LATENCY=3). A 3-stage FPMul
// stand-in returns exact products for the listed float pairs and a^b for
// anything else, so every response identifies its operands.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 3;

  logic clk      = 1'b0;
  logic areset_n = 1'b0;

  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fp_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000; // 1*1 = 1
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2*2 = 4
      {32'h40400000, 32'h40400000}: return 32'h41100000; // 3*3 = 9
      {32'h40800000, 32'h40800000}: return 32'h41800000; // 4*4 = 16
      {32'h40000000, 32'h40400000}: return 32'h40C00000; // 2*3 = 6
      default:                      return a ^ b;
    endcase
  endfunction

  logic [31:0] pipe_q [LATENCY];

  always @(posedge clk) begin
    pipe_q[LATENCY-1] <= fmul(bus.mul_a, bus.mul_b);
    for (int s = 0; s < LATENCY - 1; s++) pipe_q[s] <= pipe_q[s+1];
  end

  assign bus.mul_q = pipe_q[0];

  int errors = 0;
  int checks = 0;

  logic [31:0] ops  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] prods[4] = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h41800000};
  logic [31:0] opa  [4] = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
  logic [31:0] opb  [4] = '{32'h0000000A, 32'h000000B0, 32'h00000C00, 32'h0000D000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]        = v;
    bus.req_a[32*i +: 32]   = a;
    bus.req_b[32*i +: 32]   = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  initial begin
    logic [3:0] exp_oh;

    // Reset held with every requester valid: nothing may be granted.
    clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, opa[i], opb[i]);
    areset_n = 1'b0;
    repeat (2) next_cycle();
    sample();
    check("rst.req_ready",  32'(bus.req_ready),  32'h0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst.busy",       32'(bus.busy),       32'h0);
    check("rst.mul_a",      bus.mul_a,           32'h0);
    check("rst.mul_b",      bus.mul_b,           32'h0);

    // Single request from requester 2 in the first cycle out of reset.
    next_cycle();
    areset_n = 1'b1;
    clear_reqs();
    set_req(2, 1'b1, 32'h40000000, 32'h40400000);
    sample();
    check("single.req_ready", 32'(bus.req_ready), 32'h4);
    check("single.mul_a",     bus.mul_a,          32'h40000000);
    check("single.mul_b",     bus.mul_b,          32'h40400000);
    next_cycle();
    clear_reqs();
    sample();
    check("single.busy_t1",  32'(bus.busy),       32'h1);
    check("single.resp_t1",  32'(bus.resp_valid), 32'h0);
    check("single.idle_mux", bus.mul_a,           32'h0);
    next_cycle();
    sample();
    check("single.resp_t2", 32'(bus.resp_valid), 32'h0);
    next_cycle();
    sample();
    check("single.resp_t3", 32'(bus.resp_valid), 32'h4);
    check("single.data_t3", bus.resp_data,       32'h40C00000);
    next_cycle();
    sample();
    check("single.resp_t4", 32'(bus.resp_valid), 32'h0);
    check("single.busy_t4", 32'(bus.busy),       32'h0);

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    // Requesters 1 and 3 always valid: 1 always wins.
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      set_req(1, 1'b1, opa[1], opb[1]);
      set_req(3, 1'b1, opa[3], opb[3]);
      sample();
      check("fixed.req_ready", 32'(bus.req_ready), 32'h2);
      check("fixed.mul_a",     bus.mul_a,          opa[1]);
    end
    next_cycle();
    clear_reqs();
    repeat (4) next_cycle();
`else
    // Wrap: rr_ptr is 3 after granting 2; requesters 0 and 3 valid.
    next_cycle();
    set_req(0, 1'b1, opa[0], opb[0]);
    set_req(3, 1'b1, opa[3], opb[3]);
    sample();
    check("wrap.grant3", 32'(bus.req_ready), 32'h8);
    check("wrap.mul_a3", bus.mul_a,          opa[3]);
    next_cycle();
    set_req(3, 1'b0, 32'h0, 32'h0);
    sample();
    check("wrap.grant0", 32'(bus.req_ready), 32'h1);
    check("wrap.mul_a0", bus.mul_a,          opa[0]);
    next_cycle();
    clear_reqs();
    sample();
    check("wrap.resp_t2", 32'(bus.resp_valid), 32'h0);
    next_cycle();
    sample();
    check("wrap.resp3",   32'(bus.resp_valid), 32'h8);
    check("wrap.data3",   bus.resp_data,       opa[3] ^ opb[3]);
    next_cycle();
    sample();
    check("wrap.resp0",   32'(bus.resp_valid), 32'h1);
    check("wrap.data0",   bus.resp_data,       opa[0] ^ opb[0]);
`endif

    // Back-to-back from requester 1; its first response overlaps its last request.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c < 4) set_req(1, 1'b1, ops[c], ops[c]);
      else       clear_reqs();
      sample();
      if (c < 4) check("b2b.req_ready", 32'(bus.req_ready), 32'h2);
      if (c >= 3) begin
        check("b2b.resp_valid", 32'(bus.resp_valid), 32'h2);
        check("b2b.resp_data",  bus.resp_data,       prods[c-3]);
      end
    end
    next_cycle();
    sample();
    check("b2b.drained_busy", 32'(bus.busy),       32'h0);
    check("b2b.drained_resp", 32'(bus.resp_valid), 32'h0);

    // Reset mid-flight: three accepts, then reset; all products discarded.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      set_req(0, 1'b1, opa[0], opb[0]);
    end
    next_cycle();
    areset_n = 1'b0;
    clear_reqs();
    for (int c = 0; c < 5; c++) begin
      sample();
      check("midrst.resp_valid", 32'(bus.resp_valid), 32'h0);
      check("midrst.busy",       32'(bus.busy),       32'h0);
      next_cycle();
    end
    areset_n = 1'b1;

`ifndef FP_MUL_ARB_FIXED_PRIO_EN
    // Full contention from rr_ptr=0: grants 0,1,2,3,0,...; responses 3 cycles later.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, opa[i], opb[i]);
    for (int c = 0; c < 11; c++) begin
      sample();
      if (c < 8) begin
        exp_oh = 4'b0001 << (c % 4);
        check("cont.req_ready", 32'(bus.req_ready), 32'(exp_oh));
        check("cont.mul_a",     bus.mul_a,          opa[c % 4]);
      end
      if (c >= 3) begin
        exp_oh = 4'b0001 << ((c - 3) % 4);
        check("cont.resp_valid", 32'(bus.resp_valid), 32'(exp_oh));
        check("cont.resp_data",  bus.resp_data,       opa[(c-3) % 4] ^ opb[(c-3) % 4]);
      end
      next_cycle();
      if (c == 7) clear_reqs();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
